// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg
// Shared definitions for the voice mixer and its neighbours in the DAC path:
//   - mix_state_e : mixer FSM states (IDLE / REQ / DONE)
//   - acc_width() : accumulator width that cannot overflow for a given voice count
//   - sat_hi() / sat_lo() : signed clamp bounds for an output width
//   - midscale() : offset-binary code for silence
package audio_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mix_state_e;

    // Default output width used across the DAC path.
    localparam int DEFAULT_AUDIO_WIDTH = 8;

    // Summing N samples of width W needs clog2(N) extra bits of headroom.
    function automatic int acc_width(int audio_width, int num_voices);
        return audio_width + $clog2(num_voices);
    endfunction

    function automatic int sat_hi(int audio_width);
        return (1 << (audio_width - 1)) - 1;
    endfunction

    function automatic int sat_lo(int audio_width);
        return -(1 << (audio_width - 1));
    endfunction

    // Offset-binary zero level (0x80 for 8 bits).
    function automatic int midscale(int audio_width);
        return 1 << (audio_width - 1);
    endfunction

endpackage

// File: rtl/audio_voice_mixer_if.sv
// audio_voice_mixer_if
// Request/acknowledge bus between the mixer (master) and the oscillator
// voices (slave).
//   voice_sel    : index of the voice being requested (master -> slave)
//   voice_req    : request for the sample of voice_sel (master -> slave)
//   voice_ack    : voice_sample valid this cycle       (slave -> master)
//   voice_sample : signed two's-complement sample      (slave -> master)
interface audio_voice_mixer_if #(
    parameter int NUM_VOICES  = 4,
    parameter int AUDIO_WIDTH = 8
);
    logic [$clog2(NUM_VOICES)-1:0] voice_sel;
    logic                          voice_req;
    logic                          voice_ack;
    logic [AUDIO_WIDTH-1:0]        voice_sample;

    modport master (
        output voice_sel,
        output voice_req,
        input  voice_ack,
        input  voice_sample
    );

    modport slave (
        input  voice_sel,
        input  voice_req,
        output voice_ack,
        output voice_sample
    );
endinterface

// File: rtl/sample_rate_divider.sv
// sample_rate_divider
// Free-running counter 0..CLK_DIV-1; tick is high during the terminal count.
// Shared by any consumer that needs the audio sample rate.
//   clock : system clock (rising edge)
//   reset : asynchronous, active-high; counter returns to 0
//   tick  : one-cycle pulse every CLK_DIV clocks
module sample_rate_divider #(
    parameter int CLK_DIV = 256
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = (count_q == CNT_W'(CLK_DIV - 1));
        count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/audio_voice_mixer.sv
// audio_voice_mixer
// Once per sample period, fetches one signed sample from each voice over the
// request/acknowledge bus, sums them, scales by MIX_SHIFT, limits to the
// output width and presents it as unsigned offset-binary for the sigma-delta
// converter.
//   clock, reset  : system clock / asynchronous active-high reset
//   voice_enable  : per-voice enable, looked at when the voice is visited
//   voice_bus     : master side of the voice request/ack bus
//   audio_out     : registered mix, held between strobes (0x80 = silence)
//   sample_strobe : one-cycle pulse with the first cycle of a new audio_out
//   overrun       : one-cycle pulse after a tick that arrived mid-mix
// Build option: define MIXER_SATURATE_EN to clamp out-of-range sums to the
// signed output range; otherwise the low bits are kept and the sum wraps.
module audio_voice_mixer
    import audio_mixer_pkg::*;
#(
    parameter int AUDIO_WIDTH = 8,
    parameter int NUM_VOICES  = 4,
    parameter int CLK_DIV     = 256,
    parameter int MIX_SHIFT   = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_VOICES-1:0]  voice_enable,
    audio_voice_mixer_if.master    voice_bus,
    output logic [AUDIO_WIDTH-1:0] audio_out,
    output logic                   sample_strobe,
    output logic                   overrun
);
    localparam int ACC_W = acc_width(AUDIO_WIDTH, NUM_VOICES);
    localparam int SEL_W = $clog2(NUM_VOICES);
    localparam logic [AUDIO_WIDTH-1:0] MIDSCALE_CODE = AUDIO_WIDTH'(midscale(AUDIO_WIDTH));
    localparam logic [SEL_W-1:0]       LAST_VOICE    = SEL_W'(NUM_VOICES - 1);

    logic tick;

    sample_rate_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_divider (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    mix_state_e               state_q,   state_d;
    logic [SEL_W-1:0]         sel_q,     sel_d;
    logic                     req_q,     req_d;
    logic signed [ACC_W-1:0]  acc_q,     acc_d;
    logic [AUDIO_WIDTH-1:0]   audio_q,   audio_d;
    logic                     strobe_q,  strobe_d;
    logic                     overrun_q, overrun_d;

    logic [SEL_W-1:0]         sel_inc;
    logic signed [ACC_W-1:0]  sample_ext;
    logic [AUDIO_WIDTH-1:0]   clipped;

`ifdef MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(AUDIO_WIDTH));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(AUDIO_WIDTH));
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_q >>> MIX_SHIFT;
        if (shifted > SAT_HI) begin
            clipped = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_LO) begin
            clipped = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
        end else begin
            clipped = shifted[AUDIO_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        clipped = AUDIO_WIDTH'(acc_q >>> MIX_SHIFT);
    end
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        req_d      = req_q;
        acc_d      = acc_q;
        audio_d    = audio_q;
        strobe_d   = 1'b0;
        // A tick outside IDLE is dropped; the mix in progress carries on.
        overrun_d  = tick && (state_q != IDLE);
        sel_inc    = sel_q + SEL_W'(1);
        sample_ext = {{(ACC_W-AUDIO_WIDTH){voice_bus.voice_sample[AUDIO_WIDTH-1]}},
                      voice_bus.voice_sample};

        case (state_q)
            IDLE: begin
                acc_d = '0;
                req_d = 1'b0;
                sel_d = '0;
                if (tick) begin
                    state_d = REQ;
                    req_d   = voice_enable[0];
                end
            end
            REQ: begin
                // A disabled voice (req low) finishes after one cycle; an
                // enabled one waits for its ack. Ack is ignored with req low.
                if (!req_q || voice_bus.voice_ack) begin
                    if (req_q) begin
                        acc_d = acc_q + sample_ext;
                    end
                    if (sel_q == LAST_VOICE) begin
                        state_d = DONE;
                        req_d   = 1'b0;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_inc;
                        req_d = voice_enable[sel_inc];
                    end
                end
            end
            DONE: begin
                // Offset-binary: invert the sign bit of the signed result.
                audio_d  = {~clipped[AUDIO_WIDTH-1], clipped[AUDIO_WIDTH-2:0]};
                strobe_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            req_q     <= 1'b0;
            acc_q     <= '0;
            audio_q   <= MIDSCALE_CODE;
            strobe_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            req_q     <= req_d;
            acc_q     <= acc_d;
            audio_q   <= audio_d;
            strobe_q  <= strobe_d;
            overrun_q <= overrun_d;
        end
    end

    assign voice_bus.voice_sel = sel_q;
    assign voice_bus.voice_req = req_q;
    assign audio_out           = audio_q;
    assign sample_strobe       = strobe_q;
    assign overrun             = overrun_q;
endmodule

// File: doc/audio_voice_mixer.md
# audio_voice_mixer

Upstream stage of the sigma-delta DAC path. Once per sample period it gathers one signed sample from each of NUM_VOICES oscillator voices over a request/acknowledge bus and sums them. It scales, clips and converts the sum to unsigned offset-binary, then holds the result on `audio_out` as the parallel input word for the 1-bit sigma-delta converter.

## Interface
- `AUDIO_WIDTH`, 8: output sample width, unsigned offset-binary.
- `NUM_VOICES`, 4: voices per sample period; ≥2.
- `CLK_DIV`, 256: clocks per sample period; must be ≥ NUM_VOICES+3.
- `MIX_SHIFT`, 1: arithmetic right shift applied to the voice sum.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `voice_enable`  in  NUM_VOICES  per-voice enable, sampled when the voice is visited.
- `voice_sel`  out  $clog2(NUM_VOICES)  index of the voice being requested.
- `voice_req`  out  1  request for the sample of voice `voice_sel`.
- `voice_ack`  in  1  voice sample valid this cycle.
- `voice_sample`  in  AUDIO_WIDTH  signed two's-complement voice sample.
- `audio_out`  out  AUDIO_WIDTH  mixed sample, registered, held between strobes.
- `sample_strobe`  out  1  one-cycle pulse, coincident with the first cycle of a new `audio_out`.
- `overrun`  out  1  one-cycle pulse when a sample tick arrives while a mix is in progress.

## Operation
- Divider counts 0..CLK_DIV-1 and wraps. The terminal count is the sample tick.
- FSM states: IDLE, REQ, DONE.
- IDLE: the accumulator is cleared. On tick → REQ with `voice_sel`=0.
- REQ, voice enabled: `voice_req`=1, held with `voice_sel` stable until `voice_ack`. On ack, accumulator += sign-extended `voice_sample` and the index advances.
- REQ, voice disabled: `voice_req`=0. Contributes 0 and advances after one cycle.
- REQ, last voice done → DONE.
- `voice_ack` is ignored while `voice_req`=0.
- DONE: the result is computed and registered, `sample_strobe` is set, and the FSM returns to IDLE.
- Accumulator width is AUDIO_WIDTH+$clog2(NUM_VOICES), signed; the sum never overflows.
- Result = (acc >>> MIX_SHIFT), limited to the signed AUDIO_WIDTH range (see Configuration), then offset by +2^(AUDIO_WIDTH-1), i.e. MSB inverted.
- Tick while not IDLE: `overrun` pulses, the tick is dropped, and the mix in progress completes normally. The divider never stalls.

## Timing
- Reset values:
  - `audio_out` = 2^(AUDIO_WIDTH-1) (0x80 for the default width, silence).
  - `voice_req`, `voice_sel`, `sample_strobe`, `overrun` = 0.
  - Divider = 0, FSM = IDLE, accumulator = 0.
- Tick at cycle T → first `voice_req` at T+1.
- With every voice acked in its first request cycle, or disabled: the last voice completes at T+NUM_VOICES. DONE occurs at T+NUM_VOICES+1. `audio_out` and `sample_strobe` update at T+NUM_VOICES+2.
- `voice_req`/`voice_sel` are registered outputs. They drop or advance in the cycle after an ack.
- `overrun` is registered and asserts the cycle after the dropped tick.
- Reset mid-mix aborts immediately. Outputs return to reset values and the partial sum is discarded.

## Configuration
- `MIXER_SATURATE_EN` defined: a shifted sum outside [-2^(AUDIO_WIDTH-1), 2^(AUDIO_WIDTH-1)-1] clamps to the nearest bound.
- Undefined: the low AUDIO_WIDTH bits of the shifted sum are used, and out-of-range sums wrap.
- Ports, latency and all other behaviour are identical in both builds.

## Structure
- Package `audio_mixer_pkg`: FSM state enum (IDLE/REQ/DONE), accumulator-width and saturation-bound localparams/functions, and the offset-binary midscale constant.
- Sub-module `sample_rate_divider` (param CLK_DIV; ports clock, reset, tick). It is reusable by other sample-rate consumers.

## Test plan
- Reset, defaults: `audio_out`=0x80, no strobe. First `voice_req` occurs at cycle 256 after reset release, at the first tick (divider terminal count 255).
- Voices +10, +20, -6, +40, all enabled, immediate ack → sum 64 >>>1 = 32 → `audio_out`=0xA0. Strobe exactly 6 cycles after the tick.
- All voices +127:
  - With MIXER_SATURATE_EN: sum 508 >>>1 = 254 → 0xFF.
  - Without it: 254 wraps to -2 → 0x7E.
- `voice_enable`=4'b0101, voices +50, +99, +30, +99 → voices 1 and 3 never requested. Sum 80 >>>1 = 40 → 0xA8.
- Voice 2 acks 300 cycles late (CLK_DIV=256):
  - `overrun` pulses once at the next tick, and `voice_sel` stays 2 throughout.
  - The completed mix is still output.
- Reset asserted in REQ with voice_sel=2 → next cycle `voice_req`=0 and `audio_out`=0x80. A clean mix follows the first tick after release.
